// File: rtl/adder_32bit.sv
// rtl/adder_32bit.sv - registered 32-bit adder built from two 16-bit carry-lookahead slices
// Optional signed-overflow output enabled by defining ADDER_32BIT_OVF_EN.
module adder_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
`ifdef ADDER_32BIT_OVF_EN
    output logic        ovf,
`endif
    output logic        cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [8:0]  w_gc;
    logic [31:0] w_s;
    logic        w_c16;
    logic        w_c32;

    logic [31:0] r_sum;
    logic        r_cout;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Groups 0-3 form the lower slice, groups 4-7 the upper; group carries ripple.
    assign w_gc[0] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_cla
            logic [3:0] w_gg;
            logic [3:0] w_pp;
            logic       w_ci;

            assign w_gg = w_g[4*k +: 4];
            assign w_pp = w_p[4*k +: 4];
            assign w_ci = w_gc[k];

            assign w_c[4*k]   = w_ci;
            assign w_c[4*k+1] = w_gg[0] | (w_pp[0] & w_ci);
            assign w_c[4*k+2] = w_gg[1] | (w_pp[1] & w_gg[0])
                              | (w_pp[1] & w_pp[0] & w_ci);
            assign w_c[4*k+3] = w_gg[2] | (w_pp[2] & w_gg[1])
                              | (w_pp[2] & w_pp[1] & w_gg[0])
                              | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
            assign w_gc[k+1]  = w_gg[3] | (w_pp[3] & w_gg[2])
                              | (w_pp[3] & w_pp[2] & w_gg[1])
                              | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                              | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
        end
    endgenerate

    assign w_c16 = w_gc[4];
    assign w_c32 = w_gc[8];
    assign w_s   = w_p ^ w_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 32'h0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c32;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef ADDER_32BIT_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (a[31] == b[31]) && (w_s[31] != a[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    // Lower-slice carry-out is consumed internally by group 4; kept named for debug.
    logic w_unused_c16;
    assign w_unused_c16 = w_c16;

endmodule

// File: tb/tb_adder_32bit.sv
// tb/tb_adder_32bit.sv - scoreboard bench for adder_32bit with directed vectors
module tb_adder_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
`ifdef ADDER_32BIT_OVF_EN
    logic        ovf;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    adder_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
`ifdef ADDER_32BIT_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one operand pair at a negedge and record its hand-computed result.
    task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        a = va;
        b = vb;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum",  sum,         e.sum);
                chk("cout", {31'h0, cout}, {31'h0, e.cout});
`ifdef ADDER_32BIT_OVF_EN
                chk("ovf",  {31'h0, ovf},  {31'h0, e.ovf});
`endif
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_sum",  sum,  32'h0);
            chk("rst_hold_cout", {31'h0, cout}, 32'h0);
`ifdef ADDER_32BIT_OVF_EN
            chk("rst_hold_ovf",  {31'h0, ovf},  32'h0);
`endif
        end

        @(negedge clk);
        rst_n = 1'b1;
        apply(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk); apply(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        @(negedge clk); apply(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0);
        @(negedge clk); apply(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk); apply(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk); apply(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk); apply(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        @(negedge clk); apply(32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0);
        @(negedge clk); apply(32'h00FF_00FF, 32'hFF00_FF01, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk); apply(32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk); apply(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle must clear outputs before the next edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum",  sum,  32'h0);
        chk("async_rst_cout", {31'h0, cout}, 32'h0);
        @(negedge clk);
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        @(posedge clk);
        #1;
        chk("rst_edge_sum", sum, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
